// File: rtl/adam_axil_apb_bridge_tmo.sv
// AXI-Lite slave to multi-port APB4 master bridge: runtime address-map decode, DECERR on
// unmapped addresses, PREADY timeout answered with SLVERR, alternating read/write priority.
module adam_axil_apb_bridge_tmo #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NO_APBS        = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_WIDTH      = ($clog2(NO_APBS) > 0) ? $clog2(NO_APBS) : 1,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic [ADDR_WIDTH-1:0]         aw_addr,
  input  logic [2:0]                    aw_prot,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [STRB_WIDTH-1:0]         w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         ar_addr,
  input  logic [2:0]                    ar_prot,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [2:0]                    pprot,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_WIDTH-1:0]         pstrb,
  output logic                          penable,
  output logic [NO_APBS-1:0]            psel,
  input  logic [NO_APBS-1:0]            pready,
  input  logic [NO_APBS-1:0]            pslverr,
  input  logic [NO_APBS*DATA_WIDTH-1:0] prdata,
  input  logic [NO_APBS*ADDR_WIDTH-1:0] map_start,
  input  logic [NO_APBS*ADDR_WIDTH-1:0] map_end
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP, S_PAUSED} state_t;

  state_t                  state, state_nx;
  logic                    prio_wr, is_write;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [1:0]              resp_q;
  logic [TW-1:0]           tmo_cnt;

  logic                    wr_cand, rd_cand, pick_wr, accept, tmo_hit;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    hit;
  logic [IDX_WIDTH-1:0]    hit_idx;
  logic                    pready_sel, pslverr_sel;
  logic [DATA_WIDTH-1:0]   prdata_sel;

  assign wr_cand  = aw_valid && w_valid;
  assign rd_cand  = ar_valid;
  assign pick_wr  = wr_cand && (!rd_cand || prio_wr);
  assign req_addr = pick_wr ? aw_addr : ar_addr;
  // rst gates the accept so the readies read 0 while reset is held
  assign accept   = rst && (state == S_IDLE) && !pause_req && (wr_cand || rd_cand);

  // Descending scan so the lowest matching port wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NO_APBS - 1; i >= 0; i--) begin
      if (req_addr >= map_start[i*ADDR_WIDTH +: ADDR_WIDTH] &&
          req_addr <  map_end[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign pready_sel  = pready[idx_q];
  assign pslverr_sel = pslverr[idx_q];
  assign prdata_sel  = prdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    aw_ready = accept && pick_wr;
    w_ready  = accept && pick_wr;
    ar_ready = accept && !pick_wr;
    case (state)
      S_IDLE: begin
        if (pause_req)   state_nx = S_PAUSED;
        else if (accept) state_nx = hit ? S_SETUP : S_RESP;
      end
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: begin
        if (pready_sel) begin
          state_nx = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if ((is_write && b_ready) || (!is_write && r_ready))
          state_nx = pause_req ? S_PAUSED : S_IDLE;
      end
      S_PAUSED: if (!pause_req) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      prio_wr  <= 1'b1;
      is_write <= 1'b0;
      addr_q   <= '0;
      prot_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      idx_q    <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            prio_wr  <= !pick_wr;
            is_write <= pick_wr;
            addr_q   <= req_addr;
            prot_q   <= pick_wr ? aw_prot : ar_prot;
            wdata_q  <= pick_wr ? w_data : '0;
            strb_q   <= pick_wr ? w_strb : '0;
            idx_q    <= hit_idx;
            resp_q   <= hit ? 2'b00 : 2'b11;
            rdata_q  <= '0;
          end
        end
        S_SETUP: tmo_cnt <= '0;
        S_ACCESS: begin
          if (pready_sel) begin
            resp_q  <= pslverr_sel ? 2'b10 : 2'b00;
            rdata_q <= is_write ? '0 : prdata_sel;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) begin
              resp_q  <= 2'b10;
              rdata_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    psel = '0;
    for (int i = 0; i < NO_APBS; i++)
      psel[i] = (state == S_SETUP || state == S_ACCESS) && (idx_q == IDX_WIDTH'(i));
  end

  assign penable   = (state == S_ACCESS);
  assign paddr     = addr_q;
  assign pprot     = prot_q;
  assign pwrite    = is_write;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;
  assign b_valid   = (state == S_RESP) && is_write;
  assign r_valid   = (state == S_RESP) && !is_write;
  assign b_resp    = resp_q;
  assign r_resp    = resp_q;
  assign r_data    = rdata_q;
  assign pause_ack = (state == S_PAUSED);

endmodule

// File: tb/tb_adam_axil_apb_bridge_tmo.sv
// Directed bench for the AXI-Lite to APB bridge: scoreboarded responses plus cycle checks
// on the APB phases, timeout, arbitration order, pause and asynchronous reset.
module tb_adam_axil_apb_bridge_tmo;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int N   = 8;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            pause_req, pause_ack;
  logic [AW-1:0]   aw_addr, ar_addr, paddr;
  logic [2:0]      aw_prot, ar_prot, pprot;
  logic            aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
  logic [DW-1:0]   w_data, r_data, pwdata;
  logic [3:0]      w_strb, pstrb;
  logic [1:0]      b_resp, r_resp;
  logic            b_valid, b_ready, r_valid, r_ready;
  logic            pwrite, penable;
  logic [N-1:0]    psel, pready, pslverr;
  logic [N*DW-1:0] prdata;
  logic [N*AW-1:0] map_start, map_end;

  int              wait_cfg [N];
  logic [N-1:0]    err_cfg;
  int              acc_cnt;
  int              errors = 0;
  int              checks = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  adam_axil_apb_bridge_tmo #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_APBS(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .penable(penable), .psel(psel), .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .map_start(map_start), .map_end(map_end)
  );

  // APB slave model: port i raises pready after wait_cfg[i] ACCESS wait cycles
  always @(negedge clk) begin
    if (penable && psel != '0) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    for (int i = 0; i < N; i++)
      pready[i] = psel[i] && penable && (acc_cnt > wait_cfg[i]);
  end
  assign pslverr = err_cfg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {aw_ready, w_ready, ar_ready, b_valid, r_valid, penable, pwrite, pause_ack}, 0);
    chk({pfx, "_psel"}, psel, 0);
    chk({pfx, "_paddr"}, paddr, 0);
    chk({pfx, "_pwdata"}, pwdata, 0);
    chk({pfx, "_misc"}, {pstrb, pprot, b_resp, r_resp}, 0);
    chk({pfx, "_rdata"}, r_data, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       input logic [1:0] er, input logic [31:0] ed);
    bit got;
    got = 1'b0;
    sbq.push_back('{wr, er, ed});
    if (wr) begin
      aw_addr = a; aw_prot = p; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
    end else begin
      ar_addr = a; ar_prot = p; ar_valid = 1'b1;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = wr ? (aw_ready && w_ready) : ar_ready;
    end
    chk("accept", got, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
  endtask

  // n = negedges waited before a response was visible (0 = already visible)
  task automatic get_resp(output int n);
    exp_t e;
    bit   seen;
    n    = 0;
    seen = b_valid || r_valid;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = b_valid || r_valid;
    end
    chk("resp_seen", seen, 1);
    if (seen) begin
      chk("sb_nonempty", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("resp_dir", {b_valid, r_valid}, {e.wr, !e.wr});
        chk("resp_code", e.wr ? b_resp : r_resp, e.resp);
        if (!e.wr) chk("resp_rdata", r_data, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int  n, acc;
    bit  got, exp_wr;

    rst = 1'b0; pause_req = 1'b0;
    aw_addr = '0; aw_prot = '0; aw_valid = 1'b1; w_data = '0; w_strb = '0; w_valid = 1'b1;
    ar_addr = '0; ar_prot = '0; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    err_cfg = '0;
    for (int i = 0; i < N; i++) begin
      map_start[i*AW +: AW] = 32'(i) << 16;
      map_end[i*AW +: AW]   = 32'(i + 1) << 16;
      prdata[i*DW +: DW]    = 32'hC0DE_0000 | 32'(i);
      wait_cfg[i]           = 0;
    end
    prdata[5*DW +: DW] = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Write to port 3, zero wait states
    issue(1'b1, 32'h0003_0010, 32'hA5A5_0003, 4'hF, 3'b010, 2'b00, 32'h0);
    @(negedge clk);
    chk("t1_setup_psel", psel, 8'h08);
    chk("t1_setup_pen", penable, 0);
    chk("t1_paddr", paddr, 32'h0003_0010);
    chk("t1_pwdata", pwdata, 32'hA5A5_0003);
    chk("t1_pctl", {pwrite, pstrb, pprot}, {1'b1, 4'hF, 3'b010});
    @(posedge clk); #1;
    chk("t1_access", {psel, penable, b_valid}, {8'h08, 1'b1, 1'b0});
    @(posedge clk); #1;
    get_resp(n);
    chk("t1_latency", n, 0);

    // Read port 5: 3 wait cycles, slave error
    wait_cfg[5] = 3; err_cfg[5] = 1'b1;
    issue(1'b0, 32'h0005_0000, 32'h0, 4'h0, 3'b000, 2'b10, 32'h5);
    @(negedge clk);
    chk("t2_setup", {psel, pwrite, pstrb}, {8'h20, 1'b0, 4'h0});
    chk("t2_pwdata", pwdata, 0);
    get_resp(n);
    chk("t2_latency", n, 5);

    // Unmapped read: DECERR one cycle after acceptance
    issue(1'b0, 32'h0009_0000, 32'h0, 4'h0, 3'b000, 2'b11, 32'h0);
    chk("t3_nopsel", {psel, penable}, 0);
    get_resp(n);
    chk("t3_latency", n, 0);

    // Timeout on port 2, then a normal access to the same port
    wait_cfg[2] = 1000;
    issue(1'b1, 32'h0002_0008, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b10, 32'h0);
    acc = 0;
    for (int m = 0; m < 60 && !b_valid; m++) begin
      @(negedge clk);
      if (penable && psel == 8'h04) acc++;
    end
    chk("t4_access_cycles", acc, TMO);
    chk("t4_dropped", {psel, penable}, 0);
    get_resp(n);
    wait_cfg[2] = 0;
    issue(1'b1, 32'h0002_000C, 32'h1234_5678, 4'h3, 3'b000, 2'b00, 32'h0);
    get_resp(n);

    // Read hands priority back to the write side
    issue(1'b0, 32'h0001_0000, 32'h0, 4'h0, 3'b000, 2'b00, 32'hC0DE_0001);
    get_resp(n);

    // All three valids held: write, read, write, read; first B held off 5 cycles
    b_ready = 1'b0;
    aw_addr = 32'h0004_0000; w_data = 32'h4444_0000; w_strb = 4'hF; ar_addr = 32'h0006_0004;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 0);
      got = aw_ready || ar_ready;
      for (int m = 0; m < 40 && !got; m++) begin
        @(negedge clk);
        got = aw_ready || ar_ready;
      end
      chk("t5_accept", got, 1);
      chk("t5_order", {aw_ready, w_ready, ar_ready}, {exp_wr, exp_wr, !exp_wr});
      if (exp_wr) sbq.push_back('{1'b1, 2'b00, 32'h0});
      else        sbq.push_back('{1'b0, 2'b00, 32'hC0DE_0006});
      @(posedge clk); #1;
      if (k == 3) begin
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      end
      if (k == 0) begin
        for (int m = 0; m < 20 && !b_valid; m++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("t5_hold", {b_valid, b_resp}, {1'b1, 2'b00});
        end
        b_ready = 1'b1;
      end
      get_resp(n);
    end

    // Pause during a long ACCESS: transaction finishes, then bridge parks
    wait_cfg[1] = 10;
    issue(1'b1, 32'h0001_0000, 32'h0000_0011, 4'hF, 3'b000, 2'b00, 32'h0);
    @(posedge clk); #1;
    pause_req = 1'b1;
    get_resp(n);
    chk("t6_pause_ack", pause_ack, 1);
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_paused_rdy", {aw_ready, w_ready, ar_ready, pause_ack}, 4'b0001);
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    pause_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_unpause", pause_ack, 0);
    wait_cfg[1] = 0;
    issue(1'b0, 32'h0001_0020, 32'h0, 4'h0, 3'b000, 2'b00, 32'hC0DE_0001);
    get_resp(n);

    // Asynchronous reset in the middle of ACCESS drops the transaction
    wait_cfg[1] = 10;
    issue(1'b1, 32'h0001_0004, 32'h0000_0022, 4'hF, 3'b001, 2'b00, 32'h0);
    @(posedge clk); #1;
    chk("t7_in_access", {penable, psel}, {1'b1, 8'h02});
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    void'(sbq.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Priority returns to write after reset
    wait_cfg[4] = 0;
    aw_addr = 32'h0004_0010; w_data = 32'h0BAD_F00D; w_strb = 4'hF; ar_addr = 32'h0006_0000;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    sbq.push_back('{1'b1, 2'b00, 32'h0});
    @(negedge clk);
    chk("t7_prio_after_rst", {aw_ready, w_ready, ar_ready}, 3'b110);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    get_resp(n);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
